seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/alu_pkg.sv | 22 ++
 rtl/twos_abs.sv | 18 +
 rtl/seq_multiplier.sv | 161 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes and iterative-unit FSM state type
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [4:0] ALU_MULU = 5'b00100;
    localparam logic [4:0] ALU_MULS = 5'b00101;
    localparam logic [4:0] ALU_DIVU = 5'b00110;
    localparam logic [4:0] ALU_DIVS = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/twos_abs.sv
`default_nettype none
// ============================================================================
// Module      : twos_abs
// Description : Conditional two's-complement negate (magnitude or sign fix)
// Revision    : 1.0
// ============================================================================
module twos_abs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? ((~i_value) + WIDTH'(1'b1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : 8-cycle shift-add multiply-accumulate, result = A*B + C
// Revision    : 1.0
// ============================================================================
module seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [7:0]  multiplier,
    input  logic [7:0]  addend,
    input  logic [4:0]  aluop,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ZF,
    output logic        NF,
    output logic        OF
);
    import alu_pkg::*;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [23:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [24:0] r_acc;
    logic [7:0]  r_addend;
    logic [4:0]  r_op;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_result;
    logic        r_zf;
    logic        r_nf;
    logic        r_of;

    logic        w_in_signed;
    logic [15:0] w_mag_a;
    logic [7:0]  w_mag_b;
    logic [24:0] w_prod;
    logic [24:0] w_c_ext;
    logic [24:0] w_p;
    logic        w_op_mulu;
    logic        w_op_muls;
    logic [15:0] w_res;
    logic        w_zf;
    logic        w_nf;
    logic        w_of;

    // Magnitudes are taken from the live inputs so they can be captured on the start edge
    assign w_in_signed = (aluop == ALU_MULS);

    twos_abs #(.WIDTH(16)) u_abs_a (
        .i_value  (multiplicand),
        .i_negate (w_in_signed & multiplicand[15]),
        .o_value  (w_mag_a)
    );

    twos_abs #(.WIDTH(8)) u_abs_b (
        .i_value  (multiplier),
        .i_negate (w_in_signed & multiplier[7]),
        .o_value  (w_mag_b)
    );

    twos_abs #(.WIDTH(25)) u_sign_fix (
        .i_value  (r_acc),
        .i_negate (r_neg),
        .o_value  (w_prod)
    );

    assign w_op_mulu = (r_op == ALU_MULU);
    assign w_op_muls = (r_op == ALU_MULS);
    assign w_c_ext   = w_op_muls ? {{17{r_addend[7]}}, r_addend} : {17'b0, r_addend};
    assign w_p       = w_prod + w_c_ext;

    always_comb begin
        w_res = 16'h0000;
        w_of  = 1'b0;
        w_nf  = 1'b0;
        if (w_op_mulu) begin
            w_res = w_p[15:0];
            w_of  = |w_p[24:16];
        end else if (w_op_muls) begin
            w_res = w_p[15:0];
            // In range only when bits 24..15 are a pure sign extension
            w_of  = ~((&w_p[24:15]) | ~(|w_p[24:15]));
            w_nf  = w_p[15];
        end
        w_zf = (w_res == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_mcand  <= 24'd0;
            r_mplier <= 8'd0;
            r_acc    <= 25'd0;
            r_addend <= 8'd0;
            r_op     <= 5'd0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 16'h0000;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= 3'd0;
                        r_acc    <= 25'd0;
                        r_mcand  <= {8'd0, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_addend <= addend;
                        r_op     <= aluop;
                        r_neg    <= w_in_signed & (multiplicand[15] ^ multiplier[7]);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + {1'b0, r_mcand};
                    end
                    r_mcand  <= {r_mcand[22:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[7:1]};
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state  <= ST_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_res;
                    r_zf     <= w_zf;
                    r_nf     <= w_nf;
                    r_of     <= w_of;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign ZF     = r_zf;
    assign NF     = r_nf;
    assign OF     = r_of;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier against an arithmetic model
// Revision    : 1.0
// ============================================================================
module tb_seq_multiplier;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  addend;
    logic [4:0]  aluop;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ZF;
    logic        NF;
    logic        OF;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cycles;

    always #5 clk = ~clk;

    seq_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .aluop        (aluop),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .ZF           (ZF),
        .NF           (NF),
        .OF           (OF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // P = A*B + C computed exactly in 64-bit arithmetic
    function automatic void model(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                                  input logic [4:0] op, output logic [15:0] res,
                                  output logic zf, output logic nf, output logic of);
        longint p;
        p  = 0;
        of = 1'b0;
        if (op == ALU_MULU) begin
            p  = longint'(a) * longint'(b) + longint'(c);
            of = (p > 65535);
        end else if (op == ALU_MULS) begin
            p  = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
            of = (p < -32768) || (p > 32767);
        end
        res = p[15:0];
        zf  = (res == 16'h0000);
        nf  = (op == ALU_MULS) ? res[15] : 1'b0;
    endfunction

    task automatic launch(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [4:0] op);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        aluop        = op;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 8'($urandom);
        addend       = 8'($urandom);
        aluop        = 5'($urandom);
    endtask

    // lat counts edges starting with the start-sampling edge as 1
    task automatic wait_done(input int pulse_at);
        lat         = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            if (lat == pulse_at) begin
                start        = 1'b1;
                multiplicand = 16'($urandom);
                multiplier   = 8'($urandom);
                addend       = 8'($urandom);
                aluop        = ALU_MULU;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [4:0] op);
        logic [15:0] er;
        logic ez, en, eo;
        model(a, b, c, op, er, ez, en, eo);
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_busy_cycles"}, busy_cycles, 9);
        chk({tag, "_result"}, result, er);
        chk({tag, "_ZF"}, ZF, ez);
        chk({tag, "_NF"}, NF, en);
        chk({tag, "_OF"}, OF, eo);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [4:0] op, input int pulse_at);
        @(negedge clk);
        launch(a, b, c, op);
        wait_done(pulse_at);
        verify(tag, a, b, c, op);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  rc;
        logic [4:0]  rop;
        int          dvd;
        int          dvs;
        int          quo;
        int          rem;
        logic [31:0] qv;
        logic [31:0] rv;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 16'h0;
        multiplier   = 8'h0;
        addend       = 8'h0;
        aluop        = 5'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 16'h0);
        chk("reset_flags", {ZF, NF, OF}, 3'b000);
        rst = 1'b0;

        run_check("mulu_basic", 16'h0100, 8'h03, 8'h07, ALU_MULU, 0);
        run_check("mulu_ovf", 16'h1234, 8'h10, 8'h05, ALU_MULU, 0);
        run_check("muls_neg", 16'hFFFD, 8'h02, 8'hFF, ALU_MULS, 0);
        chk("muls_neg_value", result, 16'hFFF9);
        run_check("muls_ovf", 16'h8000, 8'hFF, 8'h00, ALU_MULS, 0);
        chk("muls_ovf_value", {result, OF}, {16'h8000, 1'b1});
        run_check("mulu_b_zero", 16'hBEEF, 8'h00, 8'h5A, ALU_MULU, 0);

        // Reset in the 4th CALC cycle
        @(negedge clk);
        launch(16'h00FF, 8'h11, 8'h00, ALU_MULU);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("midcalc_rst_busy", busy, 1'b0);
        chk("midcalc_rst_done", done, 1'b0);
        chk("midcalc_rst_result", result, 16'h0);
        chk("midcalc_rst_flags", {ZF, NF, OF}, 3'b000);

        run_check("start_while_busy", 16'h0FED, 8'h21, 8'h33, ALU_MULU, 4);

        // Back-to-back: start asserted while in DONE
        @(negedge clk);
        launch(16'h7FFF, 8'h7F, 8'h01, ALU_MULS);
        wait_done(0);
        verify("b2b_first", 16'h7FFF, 8'h7F, 8'h01, ALU_MULS);
        launch(16'h0003, 8'h05, 8'h02, ALU_MULU);
        wait_done(0);
        verify("b2b_second", 16'h0003, 8'h05, 8'h02, ALU_MULU);

        run_check("op_zero", 16'h1234, 8'h56, 8'h78, 5'h00, 0);
        run_check("op_divu", 16'hFFFF, 8'hFF, 8'hFF, ALU_DIVU, 0);

        for (int i = 0; i < 16; i++) begin
            ra  = 16'($urandom);
            rb  = 8'($urandom);
            rc  = 8'($urandom);
            rop = ($urandom_range(0, 1) == 0) ? ALU_MULU : ALU_MULS;
            run_check("random", ra, rb, rc, rop, 0);
        end

        // Divider round-trip: quotient*divisor + remainder reproduces the dividend
        for (int i = 0; i < 10; i++) begin
            dvd = int'($urandom_range(0, 65535));
            dvs = int'($urandom_range(1, 255));
            quo = dvd / dvs;
            rem = dvd % dvs;
            qv  = quo;
            rv  = rem;
            run_check("divu_roundtrip", qv[15:0], 8'(dvs), rv[7:0], ALU_MULU, 0);
            chk("divu_roundtrip_value", {result, OF}, {16'(dvd), 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            dvd = int'($urandom_range(0, 65535)) - 32768;
            dvs = int'($urandom_range(0, 255)) - 128;
            if (dvs == 0) dvs = 3;
            if (dvd == -32768 && dvs == -1) dvd = -32767;
            quo = dvd / dvs;
            rem = dvd % dvs;
            qv  = quo;
            rv  = rem;
            run_check("divs_roundtrip", qv[15:0], 8'(dvs), rv[7:0], ALU_MULS, 0);
            chk("divs_roundtrip_value", {result, OF}, {16'(dvd), 1'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
